// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
//   Programmable interval timer and walk-request latch serving the
//   traffic-light FSM. Three programmable durations (base, extension, yellow)
//   are counted down in seconds, where one second is DIV clock cycles.
//   'expired' pulses for one cycle when the selected interval has elapsed.
//
// Ports
//   clk          in   1      system clock
//   rst_n        in   1      asynchronous active-low reset
//   prog         in   1      program strobe (level)
//   prog_sel     in   2      00 base, 01 ext, 10 yellow, 11 restore defaults
//   prog_val     in   VAL_W  value written to the selected duration
//   start_timer  in   1      load and start the interval chosen by 'interval'
//   interval     in   2      00 base, 01 ext, 10 yellow, 11 fixed 1 s
//   expired      out  1      one-cycle pulse when the countdown reaches 0
//   walk_btn     in   1      raw pedestrian button (asynchronous)
//   wr_reset     in   1      clear the walk request
//   wr           out  1      latched walk request
//   count        out  VAL_W  remaining seconds
//   tick         out  1      one-cycle 1 Hz enable
// -----------------------------------------------------------------------------
module timer_ctrl #(
   parameter int DIV      = 27000000,
   parameter int VAL_W    = 4,
   parameter int T_BASE_D = 6,
   parameter int T_EXT_D  = 3,
   parameter int T_YEL_D  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             prog,
   input  logic [1:0]       prog_sel,
   input  logic [VAL_W-1:0] prog_val,
   input  logic             start_timer,
   input  logic [1:0]       interval,
   output logic             expired,
   input  logic             walk_btn,
   input  logic             wr_reset,
   output logic             wr,
   output logic [VAL_W-1:0] count,
   output logic             tick
);

   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [VAL_W-1:0] BASE_INIT = VAL_W'(T_BASE_D);
   localparam logic [VAL_W-1:0] EXT_INIT  = VAL_W'(T_EXT_D);
   localparam logic [VAL_W-1:0] YEL_INIT  = VAL_W'(T_YEL_D);
   localparam logic [VAL_W-1:0] ONE       = VAL_W'(1);

   logic [DIV_W-1:0] div_reg;
   logic [VAL_W-1:0] t_base_reg;
   logic [VAL_W-1:0] t_ext_reg;
   logic [VAL_W-1:0] t_yel_reg;
   logic [VAL_W-1:0] count_reg;
   logic             run_reg;
   logic             expired_reg;
   logic             auto_go_reg;
   logic             wr_reg;
   logic             btn_meta_reg;
   logic             btn_sync_reg;

   logic             tick_now;
   logic             load;
   logic [VAL_W-1:0] sel_val;
   logic [VAL_W-1:0] load_val;

   // Tick is a pure decode of the divider register, so it is glitch-free
   // and is 0 whenever the divider has just been cleared.
   assign tick_now = (div_reg == DIV_LAST);

   // auto_go gives the FSM a first expiry after reset or programming even
   // though it never issued start_timer. Programming suppresses loads.
   assign load = !prog && (start_timer || auto_go_reg);

   always_comb begin
      sel_val = ONE;
      case (interval)
         2'b00:   sel_val = t_base_reg;
         2'b01:   sel_val = t_ext_reg;
         2'b10:   sel_val = t_yel_reg;
         default: sel_val = ONE;
      endcase
      // A programmed zero would otherwise never expire; treat it as 1 s.
      load_val = (sel_val == '0) ? ONE : sel_val;
   end

   // Two-flop synchronizer for the asynchronous pedestrian button.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_meta_reg <= 1'b0;
         btn_sync_reg <= 1'b0;
      end else begin
         btn_meta_reg <= walk_btn;
         btn_sync_reg <= btn_meta_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_base_reg  <= BASE_INIT;
         t_ext_reg   <= EXT_INIT;
         t_yel_reg   <= YEL_INIT;
         div_reg     <= '0;
         count_reg   <= '0;
         run_reg     <= 1'b0;
         expired_reg <= 1'b0;
         auto_go_reg <= 1'b1;
         wr_reg      <= 1'b0;
      end else begin
         expired_reg <= 1'b0;
         if (prog) begin
            case (prog_sel)
               2'b00: t_base_reg <= prog_val;
               2'b01: t_ext_reg  <= prog_val;
               2'b10: t_yel_reg  <= prog_val;
               default: begin
                  t_base_reg <= BASE_INIT;
                  t_ext_reg  <= EXT_INIT;
                  t_yel_reg  <= YEL_INIT;
               end
            endcase
            div_reg     <= '0;
            count_reg   <= '0;
            run_reg     <= 1'b0;
            auto_go_reg <= 1'b1;
            wr_reg      <= 1'b0;
         end else begin
            div_reg <= tick_now ? '0 : div_reg + 1'b1;
            if (load) begin
               // Load wins over a coincident tick; the divider restarts so
               // the first second is a full DIV cycles.
               div_reg     <= '0;
               count_reg   <= load_val;
               run_reg     <= 1'b1;
               auto_go_reg <= 1'b0;
            end else if (run_reg && tick_now) begin
               if (count_reg <= ONE) begin
                  count_reg   <= '0;
                  run_reg     <= 1'b0;
                  expired_reg <= 1'b1;
               end else begin
                  count_reg <= count_reg - ONE;
               end
            end
            // A synchronized press overrides a simultaneous clear.
            if (btn_sync_reg) begin
               wr_reg <= 1'b1;
            end else if (wr_reset) begin
               wr_reg <= 1'b0;
            end
         end
      end
   end

   assign expired = expired_reg;
   assign wr      = wr_reg;
   assign count   = count_reg;
   assign tick    = tick_now;

endmodule

// File: tb/tb_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl
//   Drives timer_ctrl (DIV=4) with directed scenarios followed by random
//   stimulus. A reference model tracks each interval as a load edge plus a
//   length in seconds; expected counts are derived arithmetically and expected
//   expiry edges are queued for an independent monitor.
// -----------------------------------------------------------------------------
module tb_timer_ctrl;

   localparam int DIV   = 4;
   localparam int VAL_W = 4;
   localparam int TB_D  = 6;
   localparam int TE_D  = 3;
   localparam int TY_D  = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             prog = 1'b0;
   logic [1:0]       prog_sel = 2'b00;
   logic [VAL_W-1:0] prog_val = '0;
   logic             start_timer = 1'b0;
   logic [1:0]       interval = 2'b01;
   logic             walk_btn = 1'b0;
   logic             wr_reset = 1'b0;
   logic             expired;
   logic             wr;
   logic [VAL_W-1:0] count;
   logic             tick;

   timer_ctrl #(
      .DIV(DIV), .VAL_W(VAL_W), .T_BASE_D(TB_D), .T_EXT_D(TE_D), .T_YEL_D(TY_D)
   ) dut (
      .clk(clk), .rst_n(rst_n), .prog(prog), .prog_sel(prog_sel),
      .prog_val(prog_val), .start_timer(start_timer), .interval(interval),
      .expired(expired), .walk_btn(walk_btn), .wr_reset(wr_reset), .wr(wr),
      .count(count), .tick(tick)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt++;

   int tests = 0;
   int failed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s @edge %0d: got %0d, expected %0d", name, edge_cnt, act, exp);
      end
   endtask

   // ---------------- scoreboard queues ----------------
   typedef struct {
      int count;
      bit tick;
      bit wr;
   } snap_t;
   snap_t snap_q[$];
   int    exp_q[$];

   // ---------------- reference model ----------------
   int  m_t[3] = '{TB_D, TE_D, TY_D};
   bit  m_run = 1'b0;
   int  m_load_e = 0;
   int  m_n = 0;
   int  m_anchor = 0;
   bit  m_auto = 1'b1;
   bit  m_wr = 1'b0;
   int  m_count = 0;
   bit  m_rst_prev = 1'b1;
   bit  btn_by_edge[int];

   function automatic bit btn_seen(input int e);
      return btn_by_edge.exists(e) ? btn_by_edge[e] : 1'b0;
   endfunction

   // State expected just after edge e, given the inputs held before it.
   task automatic model_edge(input int e, input bit r, input bit p, input int ps,
                             input int pv, input bit st, input int iv,
                             input bit bw, input bit wrr);
      int n;
      snap_t s;
      if (r) begin
         m_t = '{TB_D, TE_D, TY_D};
         m_run = 1'b0; m_auto = 1'b1; m_anchor = e; m_wr = 1'b0; m_count = 0;
         btn_by_edge[e] = 1'b0;
         btn_by_edge[e-1] = 1'b0;
      end else begin
         btn_by_edge[e] = bw;
         if (p) begin
            if (ps == 3) m_t = '{TB_D, TE_D, TY_D};
            else m_t[ps] = pv;
            m_run = 1'b0; m_auto = 1'b1; m_anchor = e; m_count = 0; m_wr = 1'b0;
         end else begin
            if (st || m_auto) begin
               n = (iv == 3) ? 1 : m_t[iv];
               if (n == 0) n = 1;
               m_run = 1'b1; m_load_e = e; m_n = n; m_auto = 1'b0;
               m_anchor = e; m_count = n;
            end else if (m_run) begin
               if (e - m_load_e >= m_n * DIV) begin
                  m_run = 1'b0; m_count = 0;
                  exp_q.push_back(e);
               end else begin
                  m_count = m_n - (e - m_load_e) / DIV;
               end
            end
            if (btn_seen(e - 2)) m_wr = 1'b1;
            else if (wrr) m_wr = 1'b0;
         end
      end
      s.count = m_count;
      s.tick  = ((e - m_anchor) % DIV) == (DIV - 1);
      s.wr    = m_wr;
      snap_q.push_back(s);
   endtask

   // ---------------- driver ----------------
   task automatic step(input bit r, input bit p, input int ps, input int pv,
                       input bit st, input int iv, input bit bw, input bit wrr);
      @(negedge clk);
      #2;
      rst_n       = !r;
      prog        = p;
      prog_sel    = 2'(ps);
      prog_val    = VAL_W'(pv);
      start_timer = st;
      interval    = 2'(iv);
      walk_btn    = bw;
      wr_reset    = wrr;
      if (r && !m_rst_prev) begin
         #1;
         chk("async_rst_count", 32'(count), 32'd0);
         chk("async_rst_expired", 32'(expired), 32'd0);
         chk("async_rst_wr", 32'(wr), 32'd0);
         chk("async_rst_tick", 32'(tick), 32'd0);
      end
      m_rst_prev = r;
      model_edge(edge_cnt + 1, r, p, ps, pv, st, iv, bw, wrr);
   endtask

   task automatic idle(input int n, input int iv);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, iv, 0, 0);
   endtask

   task automatic start(input int iv);
      step(0, 0, 0, 0, 1, iv, 0, 0);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      snap_t s;
      if (snap_q.size() > 0) begin
         s = snap_q.pop_front();
         chk("count", 32'(count), 32'(s.count));
         chk("tick", 32'(tick), 32'(s.tick));
         chk("wr", 32'(wr), 32'(s.wr));
      end
      if (exp_q.size() > 0 && exp_q[0] == edge_cnt) begin
         void'(exp_q.pop_front());
         chk("expired_pulse", 32'(expired), 32'd1);
      end else begin
         chk("expired_idle", 32'(expired), 32'd0);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      // 1: reset, then auto-load of T_EXT (3 s) on release.
      repeat (3) step(1, 0, 0, 0, 0, 1, 0, 0);
      idle(16, 1);
      // 2: base interval, 6 s.
      start(0);
      idle(27, 0);
      // 3: program yellow to 5, then restore defaults.
      step(0, 1, 2, 5, 0, 2, 0, 0);
      idle(2, 2);
      start(2);
      idle(22, 2);
      step(0, 1, 3, 9, 1, 2, 0, 0);
      start(2);
      idle(10, 2);
      // 4: abort at count 2, then restart coincident with a tick.
      start(0);
      idle(16, 0);
      start(1);
      idle(3, 1);
      start(1);
      idle(14, 1);
      // 5: zero-length extension loads as 1 s.
      step(0, 1, 1, 0, 0, 1, 0, 0);
      idle(6, 1);
      start(1);
      idle(6, 1);
      // 6: walk request set / coincident clear / plain clear.
      step(0, 0, 0, 0, 0, 1, 1, 0);
      idle(1, 1);
      step(0, 0, 0, 0, 0, 1, 0, 1);
      idle(2, 1);
      step(0, 0, 0, 0, 0, 1, 0, 1);
      idle(2, 1);
      // Reset in the middle of a count.
      start(0);
      idle(9, 0);
      repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0);
      idle(10, 0);
      // Random traffic.
      for (int i = 0; i < 2500; i++) begin
         step($urandom_range(0, 299) == 0,
              $urandom_range(0, 59) == 0,
              int'($urandom_range(0, 3)),
              int'($urandom_range(0, 15)),
              $urandom_range(0, 24) == 0,
              int'($urandom_range(0, 3)),
              $urandom_range(0, 9) == 0,
              $urandom_range(0, 9) == 0);
      end
      idle(3, 0);
      repeat (2) @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
